tipi_mailbox: RTL and testbench

TIPI_MAILBOX -- requirements
Module: tipi_mailbox

---
 rtl/tipi_pkg.sv | 18 +
 rtl/tipi_sync_edge.sv | 32 +++
 rtl/tipi_mailbox.sv | 191 +++++++++++++++++++
 tb/tb_tipi_mailbox.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tipi_pkg.sv
// Shared definitions for the TI/Pi mailbox: Pi-side FSM state encoding,
// nibble width and the field layout of the Pi command nibble.
// Ports: none (package).
package tipi_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int CMD_DIR_BIT = 3;  // 1 = Pi writes rd[], 0 = Pi reads td[]
  localparam int CMD_CH_LSB  = 0;
  localparam int CMD_CH_MSB  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } pi_state_t;

endpackage

// File: rtl/tipi_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus one-cycle rising and
// falling edge pulses taken from the synchronized copy.
// Latency: level valid 2 clk after the raw change; edge pulse acts on the 3rd.
// Ports: clk/reset (sync, active-high), din (async in), level/rise/fall (out).
module tipi_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic q1, q2, q3;

  always_ff @(posedge clk) begin
    if (reset) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
      q3 <= 1'b0;
    end else begin
      q1 <= din;
      q2 <= q1;
      q3 <= q2;
    end
  end

  assign level = q2;
  assign rise  = q2 & ~q3;
  assign fall  = ~q2 & q3;

endmodule

// File: rtl/tipi_mailbox.sv
// TI/Pi mailbox: per channel a TI-to-Pi register td[] and a Pi-to-TI register
// rd[]; TI side is a strobed register port, Pi side a strobed nibble bus.
// Latency: TI writes land next cycle; Pi nibble strobes act 3 clk after the
// raw edge. No backpressure: the Pi paces itself with r_clk, the TI with strobes.
// Ports: clk/reset; ti_wr_stb, ti_rd_stb, ti_sel, ti_wdata, ti_rdata, ti_new,
// irq_mask, ti_extint (TI side); r_clk, r_nibrst, r_nib_in, r_nib_out,
// r_nib_oe, pi_busy (Pi side).
// Build option: define TIPI_MBOX_IRQ_EN for a registered, maskable, active-low
// ti_extint; otherwise ti_extint is held at 1 and irq_mask is ignored.
module tipi_mailbox import tipi_pkg::*; #(
  parameter  int CHANNELS = 2,
  parameter  int WIDTH    = 8,
  localparam int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int NIBS     = WIDTH / NIBBLE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ti_wr_stb,
  input  logic                ti_rd_stb,
  input  logic [SELW-1:0]     ti_sel,
  input  logic [WIDTH-1:0]    ti_wdata,
  output logic [WIDTH-1:0]    ti_rdata,
  output logic [CHANNELS-1:0] ti_new,
  input  logic [CHANNELS-1:0] irq_mask,
  output logic                ti_extint,
  input  logic                r_clk,
  input  logic                r_nibrst,
  input  logic [3:0]          r_nib_in,
  output logic [3:0]          r_nib_out,
  output logic                r_nib_oe,
  output logic                pi_busy
);

  pi_state_t state, state_nx;

  logic [WIDTH-1:0]    td [CHANNELS];
  logic [WIDTH-1:0]    rd [CHANNELS];
  logic [WIDTH-1:0]    stage;
  logic [WIDTH-1:0]    snap;
  logic [CHANNELS-1:0] pi_flag, pi_flag_nx, ti_new_nx;
  logic [2:0]          cmd_ch;
  logic                cmd_ok;
  logic [3:0]          cnt;

  logic pstb, rst_lvl, rst_fall;
  logic unused_clk_lvl, unused_clk_fall, unused_rst_rise;

  tipi_sync_edge u_sync_clk (
    .clk   (clk),
    .reset (reset),
    .din   (r_clk),
    .level (unused_clk_lvl),
    .rise  (pstb),
    .fall  (unused_clk_fall)
  );

  tipi_sync_edge u_sync_rst (
    .clk   (clk),
    .reset (reset),
    .din   (r_nibrst),
    .level (rst_lvl),
    .rise  (unused_rst_rise),
    .fall  (rst_fall)
  );

  logic [2:0]       nib_ch;
  logic             nib_ch_ok, last, commit_wr, rd_accept;
  logic [WIDTH+3:0] stage_ext, snap_ext;
  logic [WIDTH-1:0] stage_shift, snap_shift, td_sel;

  assign nib_ch      = r_nib_in[CMD_CH_MSB:CMD_CH_LSB];
  assign nib_ch_ok   = 32'(nib_ch) < CHANNELS;
  assign last        = (cnt == 4'(NIBS - 1));
  // Staging fills MSB nibble first; the snapshot drains MSB nibble first.
  assign stage_ext   = {stage, r_nib_in};
  assign stage_shift = stage_ext[WIDTH-1:0];
  assign snap_ext    = {snap, 4'h0};
  assign snap_shift  = snap_ext[WIDTH-1:0];

  assign commit_wr = (state == WDATA) && pstb && last && !rst_lvl && cmd_ok;
  assign rd_accept = (state == CMD) && pstb && !rst_lvl &&
                     !r_nib_in[CMD_DIR_BIT] && nib_ch_ok;

  always_comb begin
    td_sel = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (32'(nib_ch) == c) td_sel = td[c];
  end

  // Clears are applied before sets so a same-cycle set always wins.
  always_comb begin
    pi_flag_nx = pi_flag;
    ti_new_nx  = ti_new;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_accept && 32'(nib_ch) == c)   pi_flag_nx[c] = 1'b0;
      if (ti_wr_stb && 32'(ti_sel) == c)   pi_flag_nx[c] = 1'b1;
      if (ti_rd_stb && 32'(ti_sel) == c)   ti_new_nx[c]  = 1'b0;
      if (commit_wr && 32'(cmd_ch) == c)   ti_new_nx[c]  = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    if (rst_lvl) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:         if (rst_fall) state_nx = CMD;
        CMD:          if (pstb) state_nx = r_nib_in[CMD_DIR_BIT] ? WDATA : RDATA;
        WDATA, RDATA: if (pstb && last) state_nx = CMD;
        default:      state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        td[c] <= '0;
        rd[c] <= '0;
      end
      stage   <= '0;
      snap    <= '0;
      pi_flag <= '0;
      ti_new  <= '0;
      cmd_ch  <= '0;
      cmd_ok  <= 1'b0;
      cnt     <= '0;
    end else begin
      pi_flag <= pi_flag_nx;
      ti_new  <= ti_new_nx;
      for (int c = 0; c < CHANNELS; c++) begin
        if (ti_wr_stb && 32'(ti_sel) == c) td[c] <= ti_wdata;
        if (commit_wr && 32'(cmd_ch) == c) rd[c] <= stage_shift;
      end
      if (rst_lvl) begin
        // Abort: drop any partial transfer.
        stage <= '0;
        snap  <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          CMD: if (pstb) begin
            cmd_ch <= nib_ch;
            cmd_ok <= nib_ch_ok;
            cnt    <= '0;
            stage  <= '0;
            // Invalid channels read back as zero.
            snap   <= (!r_nib_in[CMD_DIR_BIT] && nib_ch_ok) ? td_sel : '0;
          end
          WDATA: if (pstb) begin
            stage <= stage_shift;
            cnt   <= last ? 4'd0 : cnt + 4'd1;
          end
          RDATA: if (pstb) begin
            snap <= snap_shift;
            cnt  <= last ? 4'd0 : cnt + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ti_rdata = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (32'(ti_sel) == c) ti_rdata = rd[c];
  end

  assign r_nib_oe  = (state == RDATA);
  assign r_nib_out = r_nib_oe ? snap[WIDTH-1 -: NIBBLE_W] : 4'h0;
  assign pi_busy   = (state == WDATA) || (state == RDATA);

`ifdef TIPI_MBOX_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) ti_extint <= 1'b1;
    else       ti_extint <= ~|(ti_new & irq_mask);
  end
`else
  logic unused_irq_mask;
  assign unused_irq_mask = ^irq_mask;
  assign ti_extint = 1'b1;
`endif

endmodule

// File: tb/tb_tipi_mailbox.sv
module tb_tipi_mailbox;
  import tipi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic r_clk = 1'b0, r_nibrst = 1'b0;
  logic [3:0] r_nib_in = 4'h0;

  // DUT A: CHANNELS=2, WIDTH=8
  logic       a_wr = 0, a_rd = 0, a_sel = 0;
  logic [7:0] a_wdata = 0, a_rdata;
  logic [1:0] a_new, a_mask = 2'b10;
  logic       a_extint, a_oe, a_busy;
  logic [3:0] a_nib_out;

  // DUT B: CHANNELS=8, WIDTH=16
  logic        b_wr = 0, b_rd = 0;
  logic [2:0]  b_sel = 0;
  logic [15:0] b_wdata = 0, b_rdata;
  logic [7:0]  b_new, b_mask = 8'h00;
  logic        b_extint, b_oe, b_busy;
  logic [3:0]  b_nib_out;

  tipi_mailbox #(.CHANNELS(2), .WIDTH(8)) u_a (
    .clk(clk), .reset(reset), .ti_wr_stb(a_wr), .ti_rd_stb(a_rd), .ti_sel(a_sel),
    .ti_wdata(a_wdata), .ti_rdata(a_rdata), .ti_new(a_new), .irq_mask(a_mask),
    .ti_extint(a_extint), .r_clk(r_clk), .r_nibrst(r_nibrst), .r_nib_in(r_nib_in),
    .r_nib_out(a_nib_out), .r_nib_oe(a_oe), .pi_busy(a_busy));

  tipi_mailbox #(.CHANNELS(8), .WIDTH(16)) u_b (
    .clk(clk), .reset(reset), .ti_wr_stb(b_wr), .ti_rd_stb(b_rd), .ti_sel(b_sel),
    .ti_wdata(b_wdata), .ti_rdata(b_rdata), .ti_new(b_new), .irq_mask(b_mask),
    .ti_extint(b_extint), .r_clk(r_clk), .r_nibrst(r_nibrst), .r_nib_in(r_nib_in),
    .r_nib_out(b_nib_out), .r_nib_oe(b_oe), .pi_busy(b_busy));

  logic use_b = 1'b0;
  wire [3:0] nib_out = use_b ? b_nib_out : a_nib_out;
  wire       nib_oe  = use_b ? b_oe : a_oe;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic exp_irq(input logic [1:0] nw);
`ifdef TIPI_MBOX_IRQ_EN
    return ~|(nw & 2'b10);
`else
    return 1'b1;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pi_pulse(input logic [3:0] n);
    r_nib_in = n; r_clk = 1'b1; tick(4);
    r_clk = 1'b0; tick(4);
  endtask

  task automatic pi_start();
    r_nibrst = 1'b1; tick(4);
    r_nibrst = 1'b0; tick(4);
  endtask

  task automatic pi_read_body(input int nibs, output logic [15:0] d);
    d = '0;
    for (int k = 0; k < nibs; k++) begin
      d = {d[11:0], nib_out};
      pi_pulse(4'h0);
    end
  endtask

  task automatic pi_read(input logic [2:0] ch, input int nibs, output logic [15:0] d);
    pi_pulse({1'b0, ch});
    pi_read_body(nibs, d);
  endtask

  task automatic pi_write(input logic [2:0] ch, input logic [15:0] d, input int nibs);
    logic [15:0] t;
    pi_pulse({1'b1, ch});
    for (int k = 0; k < nibs; k++) begin
      t = d >> (4 * (nibs - 1 - k));
      pi_pulse(t[3:0]);
    end
  endtask

  task automatic ti_a_wr(input logic sel, input logic [7:0] d);
    a_sel = sel; a_wdata = d; a_wr = 1'b1; tick(1);
    a_wr = 1'b0; tick(1);
  endtask

  task automatic ti_a_ack(input logic sel);
    a_sel = sel; a_rd = 1'b1; tick(1);
    a_rd = 1'b0; tick(1);
  endtask

  typedef enum int {OP_TIW, OP_PIW, OP_PIR, OP_ACK} op_e;
  typedef struct {
    op_e        op;
    logic [2:0] ch;
    logic [7:0] dat;
    logic [7:0] exp_dat;   // Pi read data for OP_PIR, else ti_rdata at sel=ch[0]
    logic [1:0] exp_new;
    logic [1:0] exp_flag;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic [31:0] act;

    tbl[0]  = '{OP_TIW, 3'd1, 8'hAA, 8'h00, 2'b00, 2'b10};
    tbl[1]  = '{OP_PIR, 3'd1, 8'h00, 8'hAA, 2'b00, 2'b00};
    tbl[2]  = '{OP_PIW, 3'd0, 8'h55, 8'h55, 2'b01, 2'b00};
    tbl[3]  = '{OP_ACK, 3'd0, 8'h00, 8'h55, 2'b00, 2'b00};
    tbl[4]  = '{OP_TIW, 3'd0, 8'h3C, 8'h55, 2'b00, 2'b01};
    tbl[5]  = '{OP_PIR, 3'd7, 8'h00, 8'h00, 2'b00, 2'b01};
    tbl[6]  = '{OP_PIR, 3'd0, 8'h00, 8'h3C, 2'b00, 2'b00};
    tbl[7]  = '{OP_PIW, 3'd6, 8'h99, 8'h55, 2'b00, 2'b00};
    tbl[8]  = '{OP_PIW, 3'd1, 8'hC3, 8'hC3, 2'b10, 2'b00};
    tbl[9]  = '{OP_PIW, 3'd0, 8'h12, 8'h12, 2'b11, 2'b00};
    tbl[10] = '{OP_ACK, 3'd1, 8'h00, 8'hC3, 2'b01, 2'b00};
    tbl[11] = '{OP_ACK, 3'd0, 8'h00, 8'h12, 2'b00, 2'b00};
    tbl[12] = '{OP_PIW, 3'd0, 8'h01, 8'h01, 2'b01, 2'b00};
    tbl[13] = '{OP_ACK, 3'd0, 8'h00, 8'h01, 2'b00, 2'b00};

    // Reset, with a TI write strobe that reset must override.
    #1;
    a_sel = 1'b1; a_wdata = 8'hEE; a_wr = 1'b1;
    tick(2);
    a_wr = 1'b0; reset = 1'b0;
    tick(1);
    chk("rst_new",    32'(a_new), 32'h0);
    chk("rst_flag",   32'(u_a.pi_flag), 32'h0);
    chk("rst_extint", 32'(a_extint), 32'h1);
    chk("rst_oe",     32'(a_oe), 32'h0);
    chk("rst_nibout", 32'(a_nib_out), 32'h0);
    chk("rst_busy",   32'(a_busy), 32'h0);
    chk("rst_rdata",  32'(a_rdata), 32'h0);
    chk("rst_state",  32'(u_a.state), 32'(IDLE));

    pi_start();
    chk("start_state", 32'(u_a.state), 32'(CMD));

    for (int i = 0; i < 14; i++) begin
      d = '0;
      case (tbl[i].op)
        OP_TIW: ti_a_wr(tbl[i].ch[0], tbl[i].dat);
        OP_PIW: pi_write(tbl[i].ch, {8'h00, tbl[i].dat}, 2);
        OP_PIR: pi_read(tbl[i].ch, 2, d);
        default: ti_a_ack(tbl[i].ch[0]);
      endcase
      a_sel = tbl[i].ch[0];
      #1;
      act = (tbl[i].op == OP_PIR) ? 32'(d[7:0]) : 32'(a_rdata);
      chk($sformatf("v%0d_dat", i),    act, 32'(tbl[i].exp_dat));
      chk($sformatf("v%0d_new", i),    32'(a_new), 32'(tbl[i].exp_new));
      chk($sformatf("v%0d_flag", i),   32'(u_a.pi_flag), 32'(tbl[i].exp_flag));
      chk($sformatf("v%0d_extint", i), 32'(a_extint), 32'(exp_irq(tbl[i].exp_new)));
      chk($sformatf("v%0d_busy", i),   32'(a_busy), 32'h0);
      chk($sformatf("v%0d_oe", i),     32'(a_oe), 32'h0);
    end

    // Pi write aborted after one nibble: nothing commits, staging discarded.
    pi_pulse(4'h9);
    pi_pulse(4'h3);
    chk("abw_busy", 32'(a_busy), 32'h1);
    r_nibrst = 1'b1; tick(4);
    chk("abw_state", 32'(u_a.state), 32'(IDLE));
    chk("abw_busy0", 32'(a_busy), 32'h0);
    r_nibrst = 1'b0; tick(4);
    a_sel = 1'b1; #1;
    chk("abw_rd1", 32'(a_rdata), 32'hC3);
    chk("abw_new", 32'(a_new), 32'h0);
    pi_write(3'd1, 16'h004D, 2);
    chk("abw_rd1b", 32'(a_rdata), 32'h4D);
    chk("abw_new2", 32'(a_new), 32'h2);
    ti_a_ack(1'b1);

    // Read abort: r_nib_oe drops on the 3rd clock after raw r_nibrst.
    pi_pulse(4'h0);
    chk("abr_oe1", 32'(a_oe), 32'h1);
    chk("abr_nib", 32'(a_nib_out), 32'h3);
    r_nibrst = 1'b1; tick(2);
    chk("abr_oe2", 32'(a_oe), 32'h1);
    tick(1);
    chk("abr_oe3", 32'(a_oe), 32'h0);
    r_nibrst = 1'b0; tick(5);

    // Strobe latency: command accepted on the 3rd clock after raw r_clk.
    r_nib_in = 4'h0; r_clk = 1'b1; tick(2);
    chk("lat_busy2", 32'(a_busy), 32'h0);
    tick(1);
    chk("lat_busy3", 32'(a_busy), 32'h1);
    chk("lat_nib",   32'(a_nib_out), 32'h3);
    r_clk = 1'b0; tick(4);
    pi_read_body(2, d);
    chk("lat_data", 32'(d[7:0]), 32'h3C);

    // ti_new set (Pi commit) and clear (TI ack) in the same cycle: set wins.
    pi_pulse(4'h8);
    pi_pulse(4'hA);
    r_nib_in = 4'hB; r_clk = 1'b1; tick(2);
    a_sel = 1'b0; a_rd = 1'b1; tick(1);
    a_rd = 1'b0; r_clk = 1'b0; tick(4);
    chk("sw_new",   32'(a_new), 32'h1);
    chk("sw_rdata", 32'(a_rdata), 32'hAB);

    // pi_flag set (TI write) and clear (read accept) same cycle: set wins,
    // and the snapshot holds the pre-write value.
    r_nib_in = 4'h1; r_clk = 1'b1; tick(2);
    a_sel = 1'b1; a_wdata = 8'h77; a_wr = 1'b1; tick(1);
    a_wr = 1'b0;
    chk("sf_busy", 32'(a_busy), 32'h1);
    chk("sf_flag", 32'(u_a.pi_flag), 32'h2);
    r_clk = 1'b0; tick(4);
    pi_read_body(2, d);
    chk("sf_data",  32'(d[7:0]), 32'hAA);
    chk("sf_flag2", 32'(u_a.pi_flag), 32'h2);
    pi_read(3'd1, 2, d);
    chk("sf_data2", 32'(d[7:0]), 32'h77);
    chk("sf_flag3", 32'(u_a.pi_flag), 32'h0);

    // Mid-run reset overriding a TI strobe.
    pi_write(3'd1, 16'h00E1, 2);
    chk("mr_new",    32'(a_new), 32'h3);
    chk("mr_extint", 32'(a_extint), 32'(exp_irq(2'b11)));
    a_sel = 1'b0; a_wdata = 8'h66; a_wr = 1'b1; reset = 1'b1; tick(1);
    a_wr = 1'b0; tick(1);
    reset = 1'b0; tick(1);
    a_sel = 1'b1; #1;
    chk("mr_new0",   32'(a_new), 32'h0);
    chk("mr_flag0",  32'(u_a.pi_flag), 32'h0);
    chk("mr_rdata",  32'(a_rdata), 32'h0);
    chk("mr_extint1", 32'(a_extint), 32'h1);
    chk("mr_state",  32'(u_a.state), 32'(IDLE));

    // Wide configuration: TI overwrite during a Pi read of the same channel.
    pi_start();
    use_b = 1'b1;
    b_sel = 3'd7; b_wdata = 16'h1234; b_wr = 1'b1; tick(1);
    b_wr = 1'b0; tick(1);
    chk("b_flag", 32'(u_b.pi_flag), 32'h80);
    pi_pulse(4'h7);
    d = {12'h000, nib_out};
    pi_pulse(4'h0);
    b_wdata = 16'hFFFF; b_wr = 1'b1; tick(1);
    b_wr = 1'b0; tick(1);
    for (int k = 0; k < 3; k++) begin
      d = {d[11:0], nib_out};
      pi_pulse(4'h0);
    end
    chk("b_data",  32'(d), 32'h1234);
    chk("b_flag2", 32'(u_b.pi_flag), 32'h80);
    chk("b_oe",    32'(nib_oe), 32'h0);
    pi_read(3'd7, 4, d);
    chk("b_data2", 32'(d), 32'hFFFF);
    chk("b_flag3", 32'(u_b.pi_flag), 32'h00);
    pi_write(3'd3, 16'hBEEF, 4);
    b_sel = 3'd3; #1;
    chk("b_rdata",  32'(b_rdata), 32'hBEEF);
    chk("b_new",    32'(b_new), 32'h08);
    chk("b_extint", 32'(b_extint), 32'h1);
    chk("b_busy",   32'(b_busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
